// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential shift-add multiplier that borrows the ALU's WIDTH-bit
// adder through the add_* ports. It does one partial-product step per RUN cycle,
// then presents the 2*WIDTH-bit product alongside a one-cycle done pulse.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product,
    output logic [WIDTH-1:0]   o_add_x,
    output logic [WIDTH-1:0]   o_add_y,
    input  logic [WIDTH-1:0]   i_add_sum,
    input  logic               i_add_cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_mcand;
    logic [CW-1:0]    r_cnt;

    logic             w_run;

    assign w_run = (r_state == S_RUN);

    // Status flags decode straight from state; product is the {acc,mq} pair,
    // which only moves on a load or in RUN, so it holds through DONE and IDLE.
    assign o_ready   = (r_state == S_IDLE);
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_product = {r_acc, r_mq};

    // The shared adder only sees non-zero operands during RUN; mq[0] selects
    // whether this step adds the multiplicand or just shifts.
    assign o_add_x = w_run ? r_acc : '0;
    assign o_add_y = (w_run && r_mq[0]) ? r_mcand : '0;

    // Controller and datapath: capture operands, take WIDTH shift-add steps,
    // hold one DONE cycle, and return to IDLE. Reset aborts immediately.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mq    <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mcand <= i_a;
                        r_mq    <= i_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Carry and sum shift right as one WIDTH+1-bit value; the
                    // bit falling out of acc becomes the next product LSB in mq.
                    r_acc   <= {i_add_cout, i_add_sum[WIDTH-1:1]};
                    r_mq    <= {i_add_sum[0], r_mq[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed vectors for alu_mul_seq at WIDTH=8. The stimulus thread
// queues each hand-computed product. A separate monitor pops the queue on every done
// pulse and also checks the adder operands during each RUN cycle.
module tb_alu_mul_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [W-1:0]   add_x;
    logic [W-1:0]   add_y;
    logic [W-1:0]   add_sum;
    logic           add_cout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   cur_a = '0;
    logic [W-1:0]   cur_b = '0;
    int             run_k = 0;

    always #5 clk = ~clk;

    // External adder that the multiplier time-shares.
    assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y};

    alu_mul_seq #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_a        (a),
        .i_b        (b),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_done     (done),
        .o_product  (product),
        .o_add_x    (add_x),
        .o_add_y    (add_y),
        .i_add_sum  (add_sum),
        .i_add_cout (add_cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare products on done; during RUN cycle k the multiplier bit
    // in play is b[k], so add_y must be a or 0 according to that bit.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected done: product 0x%0h with nothing expected", product);
            end else begin
                chk("product", 32'(product), 32'(exp_q.pop_front()));
            end
            run_k = 0;
        end else if (busy) begin
            if (run_k < W) chk("add_y in RUN", 32'(add_y), cur_b[run_k] ? 32'(cur_a) : 32'd0);
            if (run_k == 0) chk("add_x first RUN step", 32'(add_x), 32'd0);
            run_k++;
        end else begin
            chk("adder idle operands", {add_x, add_y}, 32'd0);
            run_k = 0;
        end
    end

    // Request an operation; assumes the DUT is in IDLE.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2*W-1:0] expp);
        @(negedge clk);
        chk("ready before issue", 32'(ready), 32'd1);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        cur_a = ta;
        cur_b = tb_;
        exp_q.push_back(expp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done, counting edges inclusive of the accepting edge.
    task automatic wait_done(output int lat);
        bit found = 0;
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!found) begin
            n_checks++;
            $display("FAIL done timeout: no done within 40 cycles, expected one");
        end
    endtask

    initial begin
        int lat;
        int t;
        int last;
        int nd;
        bit seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset product", 32'(product), 32'd0);
        chk("reset adder ops", {add_x, add_y}, 32'd0);
        rst = 1'b0;

        // 13*11 with latency, ready return and product hold
        issue(8'd13, 8'd11, 16'h008F);
        wait_done(lat);
        chk("done latency 13x11", 32'(lat), 32'd9);
        chk("busy in DONE", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("ready after DONE", 32'(ready), 32'd1);
        chk("done one cycle", 32'(done), 32'd0);
        repeat (5) @(posedge clk); #1;
        chk("product held in IDLE", 32'(product), 32'h008F);

        // boundary operand patterns
        issue(8'd255, 8'd255, 16'hFE01);
        wait_done(lat);
        chk("done latency 255x255", 32'(lat), 32'd9);
        issue(8'd0, 8'd200, 16'h0000);
        wait_done(lat);
        issue(8'd200, 8'd1, 16'h00C8);
        wait_done(lat);

        // second request during RUN cycle 3 is ignored; operands stay captured
        issue(8'd7, 8'd6, 16'h002A);
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready low in RUN", 32'(ready), 32'd0);
        wait_done(lat);
        chk("ready low in DONE", 32'(ready), 32'd0);
        @(posedge clk); #1;
        chk("ready after ignored start", 32'(ready), 32'd1);

        // reset in RUN cycle 4 aborts the operation
        issue(8'd100, 8'd3, 16'h012C);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort product", 32'(product), 32'd0);
        chk("abort adder ops", {add_x, add_y}, 32'd0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("no done after abort", 32'(seen), 32'd0);

        // start held high: one result every W+2 cycles
        a = 8'd3; b = 8'd5; cur_a = 8'd3; cur_b = 8'd5;
        repeat (3) exp_q.push_back(16'h000F);
        start = 1'b1;
        t = 0; last = -1; nd = 0;
        for (int i = 0; i < 60 && nd < 3; i++) begin
            @(negedge clk);
            t++;
            if (done) begin
                nd++;
                if (last >= 0) chk("done period", 32'(t - last), 32'd10);
                last = t;
                if (nd == 3) start = 1'b0;
            end
        end
        chk("held-start done count", 32'(nd), 32'd3);
        repeat (2) @(posedge clk); #1;
        chk("idle after held start", 32'(ready), 32'd1);

        // rst and start on the same edge: rst wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'd5; b = 8'd5;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (!ready || busy || done) seen = 1;
        end
        chk("rst beats start", 32'(seen), 32'd0);

        repeat (3) @(posedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
